echo_timer_drop_ctrl: RTL and testbench

ECHO_TIMER_DROP_CTRL -- requirements
Module: echo_timer_drop_ctrl

---
 rtl/echo_timer_drop_ctrl_pkg.sv | 22 ++
 rtl/echo_timer_drop_ctrl_tick_gen.sv | 42 ++++
 rtl/echo_timer_drop_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_echo_timer_drop_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_timer_drop_ctrl_pkg.sv
// Shared definitions for the echo timer / drop controller: FSM state
// encoding, the saturation value of the 16-bit tick counter and the number
// of consecutive passing measurements needed when drop confirmation is built.
package echo_timer_drop_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam logic [15:0] T_SAT         = 16'hFFFF;
    localparam int          CONFIRM_DEPTH = 3;

    // Increment that sticks at T_SAT instead of wrapping to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == T_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/echo_timer_drop_ctrl_tick_gen.sv
// Time-base prescaler: emits a one-cycle tick every PRESCALE clk cycles.
// While clr is high the phase is held at zero, so the first tick after clr
// drops arrives exactly PRESCALE cycles later.
module echo_timer_drop_ctrl_tick_gen #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next phase: hold at zero while cleared, otherwise count and wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/echo_timer_drop_ctrl.sv
// Echo timer and drop controller. A start request fires a trigger pulse to
// the range sensor, times the width of the returned echo in prescaled ticks
// and decides whether a drop is enabled (armed, measured time strictly below
// the limit sampled at start, no timeout). Results and the decision are
// published together, one cycle after the DONE state, with a valid pulse.
// Optional build macro DROP_CONFIRM_EN: drop_en additionally requires
// CONFIRM_DEPTH consecutive passing measurements.
module echo_timer_drop_ctrl
    import echo_timer_drop_ctrl_pkg::*;
#(
    parameter int          PRESCALE      = 50,
    parameter int          TRIG_TICKS    = 10,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        echo,
    input  logic        arm,
    input  logic [15:0] t_lim_cfg,
    output logic        trig,
    output logic [15:0] t_act,
    output logic [15:0] t_lim,
    output logic        drop_en,
    output logic        valid,
    output logic        busy,
    output logic        timeout
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        rto_q, rto_d;
    logic        echo_s1_q, echo_s2_q, echo_s3_q;
    logic        trig_q, trig_d;
    logic [15:0] t_act_q, t_act_d;
    logic [15:0] t_lim_q, t_lim_d;
    logic        drop_en_q, drop_en_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
`ifdef DROP_CONFIRM_EN
    logic [1:0]  confirm_q, confirm_d;
`endif

    logic        tick;
    logic        echo_rise;
    logic        echo_fall;
    logic [15:0] cnt_inc;
    logic        pass;

    echo_timer_drop_ctrl_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    // Edges are taken from the synchronised echo only (s2 vs its delayed copy).
    assign echo_rise = echo_s2_q & ~echo_s3_q;
    assign echo_fall = ~echo_s2_q & echo_s3_q;
    assign cnt_inc   = sat_inc(cnt_q);

    // Next-state and output-register logic for the measurement FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        rto_d     = rto_q;
        t_act_d   = t_act_q;
        t_lim_d   = t_lim_q;
        drop_en_d = drop_en_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        pass      = 1'b0;
`ifdef DROP_CONFIRM_EN
        confirm_d = confirm_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_TRIG;
                    t_lim_d   = t_lim_cfg;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_TRIG: begin
                if (tick) begin
                    if (cnt_inc >= 16'(TRIG_TICKS)) begin
                        state_d = ST_WAIT_RISE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_WAIT_RISE: begin
                // A rise in the same cycle as the final tick still wins.
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_inc >= TIMEOUT_TICKS) begin
                        state_d = ST_DONE;
                        res_d   = T_SAT;
                        rto_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_MEASURE: begin
                // The fall cycle's own tick is included so an echo of N*PRESCALE
                // clk cycles reads back as exactly N, whatever the tick phase.
                if (echo_fall) begin
                    state_d = ST_DONE;
                    res_d   = tick ? cnt_inc : cnt_q;
                    rto_d   = 1'b0;
                end else if (tick) begin
                    if (cnt_inc >= TIMEOUT_TICKS) begin
                        state_d = ST_DONE;
                        res_d   = T_SAT;
                        rto_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                valid_d   = 1'b1;
                t_act_d   = res_q;
                timeout_d = rto_q;
                pass      = arm & (res_q < t_lim_q) & ~rto_q;
`ifdef DROP_CONFIRM_EN
                if (pass) begin
                    if (confirm_q != 2'(CONFIRM_DEPTH)) begin
                        confirm_d = confirm_q + 2'd1;
                    end
                    drop_en_d = (confirm_d == 2'(CONFIRM_DEPTH));
                end else begin
                    confirm_d = '0;
                    drop_en_d = 1'b0;
                end
`else
                drop_en_d = pass;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing arm withdraws permission immediately, in every state.
        if (!arm) begin
            drop_en_d = 1'b0;
`ifdef DROP_CONFIRM_EN
            confirm_d = '0;
`endif
        end

        trig_d = (state_d == ST_TRIG);
    end

    // Two-flop echo synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            echo_s3_q <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
        end
    end

    // FSM, counter and published-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            res_q     <= '0;
            rto_q     <= 1'b0;
            trig_q    <= 1'b0;
            t_act_q   <= '0;
            t_lim_q   <= '0;
            drop_en_q <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            rto_q     <= rto_d;
            trig_q    <= trig_d;
            t_act_q   <= t_act_d;
            t_lim_q   <= t_lim_d;
            drop_en_q <= drop_en_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DROP_CONFIRM_EN
    // Count of consecutive passing measurements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            confirm_q <= '0;
        end else begin
            confirm_q <= confirm_d;
        end
    end
`endif

    assign trig    = trig_q;
    assign t_act   = t_act_q;
    assign t_lim   = t_lim_q;
    assign drop_en = drop_en_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_echo_timer_drop_ctrl.sv
// Bench for echo_timer_drop_ctrl: stimulus pushes the expected published
// result of each measurement into a queue; a monitor pops and compares on
// every valid pulse.
module tb_echo_timer_drop_ctrl;

    localparam int          P  = 4;
    localparam int          TT = 2;
    localparam logic [15:0] TO = 16'd250;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        echo;
    logic        arm;
    logic [15:0] t_lim_cfg;
    logic        trig;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        valid;
    logic        busy;
    logic        timeout;

    typedef struct packed {
        logic [15:0] t_act;
        logic [15:0] t_lim;
        logic        drop;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   streak    = 0;
    logic last_drop = 1'b0;

    echo_timer_drop_ctrl #(
        .PRESCALE      (P),
        .TRIG_TICKS    (TT),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .echo      (echo),
        .arm       (arm),
        .t_lim_cfg (t_lim_cfg),
        .trig      (trig),
        .t_act     (t_act),
        .t_lim     (t_lim),
        .drop_en   (drop_en),
        .valid     (valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference decision: strictly-below limit, armed, no timeout; with
    // confirmation, three such results in a row are needed.
    task automatic model_done(input logic [15:0] ta, input logic [15:0] lim,
                              input logic a, input logic to, output logic d);
        logic ok;
        ok = a && !to && (ta < lim);
`ifdef DROP_CONFIRM_EN
        streak = ok ? ((streak < 3) ? streak + 1 : 3) : 0;
        d = (streak >= 3);
`else
        d = ok;
`endif
        last_drop = d;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 t_act=%0h", t_act);
            end else begin
                e = sb_q.pop_front();
                chk("t_act",   32'(t_act),   32'(e.t_act));
                chk("t_lim",   32'(t_lim),   32'(e.t_lim));
                chk("drop_en", 32'(drop_en), 32'(e.drop));
                chk("timeout", 32'(timeout), 32'(e.to));
                chk("busy_at_valid", 32'(busy), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete measurement; n = echo width in ticks.
    task automatic do_meas(input int n, input logic [15:0] lim, input logic a,
                           input bit echo_on, input bit poke_start);
        exp_t        e;
        logic        d;
        logic        to;
        logic [15:0] ta;
        int          k;
        to = !echo_on || (n >= int'(TO));
        ta = to ? 16'hFFFF : 16'(n);
        model_done(ta, lim, a, to, d);
        e = '{t_act: ta, t_lim: lim, drop: d, to: to};
        sb_q.push_back(e);

        cyc();
        arm = a;
        t_lim_cfg = lim;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("t_lim_sampled", 32'(t_lim), 32'(lim));
        chk("timeout_cleared", 32'(timeout), 32'd0);
        k = 0;
        while (trig === 1'b1 && k < 1000) begin
            k++;
            cyc();
        end
        chk("trig_len", 32'(k), 32'(P * TT));
        repeat ($urandom_range(0, 5)) cyc();

        if (echo_on) begin
            echo = 1'b1;
            for (int i = 0; i < n * P; i++) begin
                cyc();
                if (poke_start && i == 10) begin
                    start = 1'b1;
                    t_lim_cfg = ~lim;
                end else begin
                    start = 1'b0;
                end
            end
            echo = 1'b0;
            start = 1'b0;
            t_lim_cfg = lim;
            if (!to) begin
                k = 0;
                do begin
                    cyc();
                    k++;
                end while (valid !== 1'b1 && k < 20);
                chk("fall_to_valid", 32'(k), 32'd4);
            end
        end

        k = 0;
        while (busy === 1'b1 && k < 3000) begin
            cyc();
            k++;
        end
        chk("returns_idle", 32'(busy), 32'd0);
        repeat (3) cyc();
    endtask

    initial begin
        int n;
        logic [15:0] lim;
        logic a;
        rst_n = 1'b0;
        start = 1'b0;
        echo = 1'b0;
        arm = 1'b0;
        t_lim_cfg = '0;
        #22;
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_t_act", 32'(t_act), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_en", 32'(drop_en), 32'd0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        do_meas(100, 16'd200, 1'b1, 1'b1, 1'b0);
        do_meas(120, 16'd200, 1'b1, 1'b1, 1'b1);
        do_meas(60, 16'd200, 1'b1, 1'b1, 1'b0);
        chk("drop_en_hold", 32'(drop_en), 32'(last_drop));
        arm = 1'b0;
        streak = 0;
        cyc();
        chk("arm_low_clears", 32'(drop_en), 32'd0);

        do_meas(200, 16'd200, 1'b1, 1'b1, 1'b0);
        do_meas(150, 16'd300, 1'b0, 1'b1, 1'b0);
        do_meas(0, 16'd300, 1'b1, 1'b0, 1'b0);
        chk("timeout_sticky", 32'(timeout), 32'd1);
        do_meas(int'(TO) + 5, 16'd400, 1'b1, 1'b1, 1'b0);

        do_meas(30, 16'd100, 1'b1, 1'b1, 1'b0);
        do_meas(40, 16'd100, 1'b1, 1'b1, 1'b0);
        do_meas(50, 16'd100, 1'b1, 1'b1, 1'b0);
        do_meas(120, 16'd100, 1'b1, 1'b1, 1'b0);
        do_meas(20, 16'd100, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a measurement.
        arm = 1'b1;
        t_lim_cfg = 16'd300;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (trig === 1'b1 && n < 1000) begin
            n++;
            cyc();
        end
        echo = 1'b1;
        repeat (40) cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_trig", 32'(trig), 32'd0);
        chk("mid_rst_t_act", 32'(t_act), 32'd0);
        chk("mid_rst_t_lim", 32'(t_lim), 32'd0);
        chk("mid_rst_drop_en", 32'(drop_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        streak = 0;
        echo = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (30) cyc();
        chk("post_rst_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(1, 150);
            lim = ($urandom_range(0, 3) == 0) ? 16'(n) : 16'($urandom_range(1, 200));
            a = ($urandom_range(0, 3) != 0);
            do_meas(n, lim, a, 1'b1, 1'b0);
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
